// File: rtl/text_pkg.sv
// Shared character constants and reader FSM state type for the text buffer.
package text_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_NUL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_CR,
    ST_LF,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/text_buffer_reader_if.sv
// Byte-stream valid/ready link from the text buffer reader to a downstream sink.
interface text_buffer_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/text_buffer_reader.sv
// Row-major reader of the character buffer, streaming bytes with CR/LF per row.
// Optional macro TEXT_READER_SKIP_NUL_EN drops NUL cells from the stream.
module text_buffer_reader
  import text_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(ROWS)-1:0] r_row,
  output logic [$clog2(COLS)-1:0] r_col,
  input  logic [DATA_WIDTH-1:0]   rdata,
  text_buffer_reader_if.master    tx
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] D_CR  = DATA_WIDTH'(CHAR_CR);
  localparam logic [DATA_WIDTH-1:0] D_LF  = DATA_WIDTH'(CHAR_LF);
  localparam logic [DATA_WIDTH-1:0] D_NUL = DATA_WIDTH'(CHAR_NUL);

  rd_state_e             state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  xfer;
  logic                  skip;

`ifdef TEXT_READER_SKIP_NUL_EN
  assign skip = (rdata == D_NUL);
`else
  assign skip = 1'b0;
`endif

  assign xfer = valid_q && tx.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        // A skipped NUL advances exactly as a transferred byte would.
        if (skip) begin
          if (col_q == COL_LAST) begin
            state_d = ST_CR;
            data_d  = D_CR;
            valid_d = 1'b1;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_READ;
          end
        end else begin
          data_d  = rdata;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (col_q == COL_LAST) begin
            state_d = ST_CR;
            data_d  = D_CR;
          end else begin
            col_d   = col_q + 1'b1;
            valid_d = 1'b0;
            state_d = ST_READ;
          end
        end
      end
      ST_CR: begin
        if (xfer) begin
          data_d  = D_LF;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign r_row       = row_q;
  assign r_col       = col_q;
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

endmodule

// File: tb/tb_text_buffer_reader.sv
module tb_text_buffer_reader;

  localparam int BUDGET = 3000;

  typedef logic [7:0] bq_t [$];

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       row_a;
  logic [1:0] col_a;
  logic [1:0] row_b;
  logic [2:0] col_b;
  logic [7:0] rdata_a, rdata_b;
  logic       tx_ready;

  logic [7:0] memA [0:1][0:3];
  logic [7:0] memB [0:2][0:4];

  bq_t got_a, got_b;
  int  done_cnt_a = 0;
  int  done_cnt_b = 0;
  int  checks     = 0;
  int  failures   = 0;
  int  ready_mode = 0;

  text_buffer_reader_if #(.DATA_WIDTH(8)) txa ();
  text_buffer_reader_if #(.DATA_WIDTH(8)) txb ();

  assign txa.tx_ready = tx_ready;
  assign txb.tx_ready = tx_ready;

  text_buffer_reader #(.DATA_WIDTH(8), .ROWS(2), .COLS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .r_row(row_a), .r_col(col_a), .rdata(rdata_a), .tx(txa.master)
  );

  text_buffer_reader #(.DATA_WIDTH(8), .ROWS(3), .COLS(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .r_row(row_b), .r_col(col_b), .rdata(rdata_b), .tx(txb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM models and stream monitors
  always @(posedge clk) begin
    rdata_a <= memA[row_a][col_a];
    rdata_b <= (row_b < 3 && col_b < 5) ? memB[row_b][col_b] : 8'h00;
    if (txa.tx_valid && txa.tx_ready) got_a.push_back(txa.tx_data);
    if (txb.tx_valid && txb.tx_ready) got_b.push_back(txb.tx_data);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; check handshake hold rules and B address bounds across the edge.
  task automatic tick();
    logic       pv_a, pv_b, pr;
    logic [7:0] pd_a, pd_b;
    pv_a = txa.tx_valid; pd_a = txa.tx_data;
    pv_b = txb.tx_valid; pd_b = txb.tx_data;
    pr   = tx_ready;
    @(negedge clk);
    if (rst_n && pv_a && !pr) begin
      chk("hold_valid_a", {31'd0, txa.tx_valid}, 32'd1);
      chk("hold_data_a", {24'd0, txa.tx_data}, {24'd0, pd_a});
    end
    if (rst_n && pv_b && !pr) begin
      chk("hold_valid_b", {31'd0, txb.tx_valid}, 32'd1);
      chk("hold_data_b", {24'd0, txb.tx_data}, {24'd0, pd_b});
    end
    if (busy_b) begin
      chk("col_b_bound", {31'd0, (col_b <= 3'd4)}, 32'd1);
      chk("row_b_bound", {31'd0, (row_b <= 2'd2)}, 32'd1);
    end
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  endtask

  function automatic bq_t model_frame(input int rows, input int cols, input bit use_b);
    bq_t q;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        logic [7:0] ch;
        ch = use_b ? memB[r][c] : memA[r][c];
`ifdef TEXT_READER_SKIP_NUL_EN
        if (ch != 8'h00) q.push_back(ch);
`else
        q.push_back(ch);
`endif
      end
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  task automatic load_abcd();
    for (int c = 0; c < 4; c++) begin
      memA[0][c] = 8'h41 + 8'(c);
      memA[1][c] = 8'h45 + 8'(c);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int dbase);
    int n = 0;
    while (done_cnt_a == dbase && n < BUDGET) begin
      tick();
      n++;
    end
    chk("done_a_seen", {31'd0, (done_cnt_a != dbase)}, 32'd1);
    tick();
    chk("busy_a_after_done", {31'd0, busy_a}, 32'd0);
    chk("done_a_once", done_cnt_a - dbase, 32'd1);
  endtask

  task automatic cmp_frame_a(input string tag, input int base);
    bq_t exp;
    exp = model_frame(2, 4, 1'b0);
    chk({tag, "_len"}, got_a.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < got_a.size())
        chk({tag, "_byte"}, {24'd0, got_a[base + i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int base, dbase, n;
    bit found;
    bq_t expb;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_ready = 1'b1;
    load_abcd();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        memB[r][c] = 8'h20;
    tick(); tick();
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_valid", {31'd0, txa.tx_valid}, 32'd0);
    chk("rst_data", {24'd0, txa.tx_data}, 32'd0);
    chk("rst_addr", {29'd0, row_a, col_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1: ABCD/EFGH with ready always high, plus start-to-valid latency
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    chk("lat_busy", {31'd0, busy_a}, 32'd1);
    chk("lat_valid0", {31'd0, txa.tx_valid}, 32'd0);
    tick();
    chk("lat_valid1", {31'd0, txa.tx_valid}, 32'd0);
    tick();
    chk("lat_valid2", {31'd0, txa.tx_valid}, 32'd1);
    chk("lat_data", {24'd0, txa.tx_data}, 32'h41);
    wait_done_a(dbase);
    chk("frame1_len12", got_a.size() - base, 32'd12);
    cmp_frame_a("frame1", base);

    // Frame 2: random contents with random ready
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        memA[r][c] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    ready_mode = 1;
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    wait_done_a(dbase);
    cmp_frame_a("frame_rand", base);
    ready_mode = 0; tx_ready = 1'b1;
    load_abcd();

    // Stall for 5 cycles while 0x42 is presented
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    found = 1'b0; n = 0;
    while (!found && n < BUDGET) begin
      if (txa.tx_valid && txa.tx_data == 8'h42) found = 1'b1;
      else begin tick(); n++; end
    end
    chk("stall_found", {31'd0, found}, 32'd1);
    ready_mode = 2; tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, txa.tx_valid}, 32'd1);
      chk("stall_data", {24'd0, txa.tx_data}, 32'h42);
      tick();
    end
    ready_mode = 0; tx_ready = 1'b1;
    wait_done_a(dbase);
    cmp_frame_a("frame_stall", base);

    // start pulsed again mid-frame is ignored
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    for (int k = 0; k < 7; k++) tick();
    start_a = 1'b1; tick(); tick(); start_a = 1'b0;
    wait_done_a(dbase);
    cmp_frame_a("frame_restart", base);
    for (int k = 0; k < 10; k++) tick();
    chk("no_second_frame", got_a.size() - base, 32'd12);
    chk("idle_after", {31'd0, busy_a}, 32'd0);

    // Reset while the second row's CR is presented
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    found = 1'b0; n = 0;
    while (!found && n < BUDGET) begin
      if (got_a.size() - base == 10 && txa.tx_valid && txa.tx_data == 8'h0D) found = 1'b1;
      else begin tick(); n++; end
    end
    chk("cr2_found", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy_a}, 32'd0);
    chk("mrst_done", {31'd0, done_a}, 32'd0);
    chk("mrst_valid", {31'd0, txa.tx_valid}, 32'd0);
    chk("mrst_data", {24'd0, txa.tx_data}, 32'd0);
    chk("mrst_addr", {29'd0, row_a, col_a}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_no_done", done_cnt_a - dbase, 32'd0);
    chk("mrst_partial", got_a.size() - base, 32'd10);
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    wait_done_a(dbase);
    cmp_frame_a("frame_after_rst", base);

    // NUL cell at (0,1)
    memA[0][1] = 8'h00;
    base = got_a.size(); dbase = done_cnt_a;
    pulse_start_a();
    wait_done_a(dbase);
`ifdef TEXT_READER_SKIP_NUL_EN
    chk("nul_len", got_a.size() - base, 32'd11);
    if (got_a.size() - base >= 2) chk("nul_b1", {24'd0, got_a[base + 1]}, 32'h43);
`else
    chk("nul_len", got_a.size() - base, 32'd12);
    if (got_a.size() - base >= 2) chk("nul_b1", {24'd0, got_a[base + 1]}, 32'h00);
`endif
    cmp_frame_a("frame_nul", base);
    load_abcd();

    // Non-power-of-2 geometry, random data and random ready
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        memB[r][c] = 8'($urandom_range(1, 255));
    ready_mode = 1;
    base = got_b.size(); dbase = done_cnt_b;
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (done_cnt_b == dbase && n < BUDGET) begin tick(); n++; end
    chk("done_b_seen", {31'd0, (done_cnt_b != dbase)}, 32'd1);
    tick();
    chk("done_b_once", done_cnt_b - dbase, 32'd1);
    chk("busy_b_after", {31'd0, busy_b}, 32'd0);
    chk("frame_b_len21", got_b.size() - base, 32'd21);
    expb = model_frame(3, 5, 1'b1);
    for (int i = 0; i < expb.size(); i++)
      if (base + i < got_b.size())
        chk("frame_b_byte", {24'd0, got_b[base + i]}, {24'd0, expb[i]});
    ready_mode = 0; tx_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
